// File: rtl/l2_bus_responder_pkg.sv
// Shared bus types for the coherence bus controller's L2 port, plus
// lane geometry for the byte-enabled backing store.
package l2_bus_responder_pkg;

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;

  typedef logic [31:0] bus_word_t;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

endpackage

// File: rtl/l2_bus_responder_sram.sv
// Word array with per-byte-lane write enables and a registered read port.
// Deliberately not reset: contents survive responder resets.
module l2_sram_model
  import l2_bus_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [NUM_LANES-1:0] byte_en,
  input  logic [IDX_W-1:0]     addr,
  input  bus_word_t            wdata,
  output bus_word_t            rdata
);

  logic [NUM_LANES-1:0][LANE_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (byte_en[b]) mem[addr][b] <= wdata[LANE_W*b +: LANE_W];
      end
    end
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/l2_bus_responder.sv
// L2-port responder: FREE/BUSY/ACCESS/ERROR handshake in front of a
// fixed-latency byte-enabled word store.
module l2_bus_responder
  import l2_bus_responder_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          LATENCY   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 l2REN,
  input  logic                 l2WEN,
  input  bus_word_t            l2addr,
  input  bus_word_t            l2store,
  input  logic [NUM_LANES-1:0] l2_byte_en,
  output l2_state_t            l2state,
  output bus_word_t            l2load
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  l2_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  bus_word_t            data_q;
  logic [NUM_LANES-1:0] be_q;
  logic                 wr_q;
  logic                 rd_vld_q;

  bus_word_t word_off;
  logic      req, req_bad, busy_done, mem_rd, mem_wr;
  bus_word_t sram_rdata;

  // Unsigned subtract: addresses below BASE_ADDR wrap high and land out of range.
  assign word_off  = (l2addr - BASE_ADDR) >> 2;
  assign req       = l2REN | l2WEN;
  assign req_bad   = (l2REN & l2WEN) | (l2addr[1:0] != 2'b00) |
                     (word_off >= 32'(MEM_WORDS));
  assign busy_done = (state_q == L2_BUSY) && req && (cnt_q == '0);
  assign mem_rd    = busy_done && !wr_q && !RST;
  assign mem_wr    = busy_done &&  wr_q && !RST;

  always_comb begin
    state_d = state_q;
    case (state_q)
      L2_FREE:   if (req) state_d = req_bad ? L2_ERROR : L2_BUSY;
      L2_BUSY: begin
        if (!req)               state_d = L2_FREE;
        else if (cnt_q == '0)   state_d = L2_ACCESS;
      end
      L2_ACCESS: state_d = L2_FREE;
      L2_ERROR:  state_d = L2_FREE;
      default:   state_d = L2_FREE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= L2_FREE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      if (state_q == L2_FREE && req) begin
        idx_q  <= word_off[IDX_W-1:0];
        data_q <= l2store;
        be_q   <= l2_byte_en;
        wr_q   <= l2WEN;
        cnt_q  <= CNT_W'(LATENCY - 1);
      end else if (state_q == L2_BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (mem_rd) rd_vld_q <= 1'b1;
    end
  end

  l2_sram_model #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_sram (
    .clk     (CLK),
    .rd_en   (mem_rd),
    .wr_en   (mem_wr),
    .byte_en (be_q),
    .addr    (idx_q),
    .wdata   (data_q),
    .rdata   (sram_rdata)
  );

  // The SRAM output register only moves on reads, so it doubles as the
  // held load value; the flag gives the reset-to-zero view.
  assign l2load  = rd_vld_q ? sram_rdata : '0;
  assign l2state = state_q;

endmodule
